// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetcher: maps the raster position onto a sprite ROM address and
// returns a two-stage registered palette index with transparency masking.
module sprite_pixel_fetch #(
   parameter int          SPR_W      = 32,
   parameter int          SPR_H      = 32,
   parameter int          FRAMES     = 4,
   parameter int          FRAME_DIV  = 8,
   parameter logic [3:0]  TRANSP_IDX = 4'h0,
   localparam int         CW         = $clog2(SPR_W),
   localparam int         RW         = $clog2(SPR_H),
   localparam int         FW         = $clog2(FRAMES),
   localparam int         AW         = FW + RW + CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    draw_x,
   input  logic [9:0]    draw_y,
   input  logic          vde,
   input  logic          vsync_pulse,
   input  logic [9:0]    spr_x,
   input  logic [9:0]    spr_y,
   input  logic          spr_en,
   input  logic          flip_h,
   input  logic          anim_en,
   output logic [AW-1:0] rom_addr,
   input  logic [3:0]    rom_data,
   output logic [3:0]    pix_index,
   output logic          pix_valid,
   output logic [FW-1:0] frame_idx
);

   localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [10:0]   x_end, y_end;
   logic          in_x, in_y, hit;
   logic [CW-1:0] col_off, col_sel;
   logic [RW-1:0] row_sel;

   logic          hit_d_q;
   logic          pix_valid_q, pix_valid_d;
   logic [3:0]    pix_index_q, pix_index_d;
   logic [DW-1:0] div_q, div_d;
   logic [FW-1:0] frame_q, frame_d;

   // Right/bottom edges are 11 bits wide so a sprite crossing 1023 clips instead of wrapping.
   assign x_end = {1'b0, spr_x} + 11'(SPR_W);
   assign y_end = {1'b0, spr_y} + 11'(SPR_H);
   assign in_x  = ({1'b0, draw_x} >= {1'b0, spr_x}) && ({1'b0, draw_x} < x_end);
   assign in_y  = ({1'b0, draw_y} >= {1'b0, spr_y}) && ({1'b0, draw_y} < y_end);
   assign hit   = spr_en && vde && in_x && in_y;

   // Low bits of the difference only depend on low bits of the operands; ~c == SPR_W-1-c.
   assign col_off = draw_x[CW-1:0] - spr_x[CW-1:0];
   assign col_sel = hit ? (flip_h ? ~col_off : col_off) : '0;
   assign row_sel = hit ? (draw_y[RW-1:0] - spr_y[RW-1:0]) : '0;

   assign rom_addr = {frame_q, row_sel, col_sel};

   always_comb begin
      pix_valid_d = hit_d_q && (rom_data != TRANSP_IDX);
      pix_index_d = pix_valid_d ? rom_data : 4'h0;
   end

   always_comb begin
      div_d   = div_q;
      frame_d = frame_q;
      if (vsync_pulse && anim_en) begin
         if (div_q == DW'(FRAME_DIV - 1)) begin
            div_d   = '0;
            frame_d = frame_q + FW'(1);
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_d_q     <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_index_q <= 4'h0;
         div_q       <= '0;
         frame_q     <= '0;
      end else begin
         hit_d_q     <= hit;
         pix_valid_q <= pix_valid_d;
         pix_index_q <= pix_index_d;
         div_q       <= div_d;
         frame_q     <= frame_d;
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_index = pix_index_q;
   assign frame_idx = frame_q;

endmodule

// File: doc/sprite_pixel_fetch.md
SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

Interface
REQ-001 Parameter SPR_W, default 32; sprite width in pixels, a power of two.
REQ-002 Parameter SPR_H, default 32; sprite height in pixels, a power of two.
REQ-003 Parameter FRAMES, default 4; animation frames, a power of two.
REQ-004 Parameter FRAME_DIV, default 8; vsync pulses per animation step.
REQ-005 Parameter TRANSP_IDX, default 4'h0; palette index treated as transparent.
REQ-006 clk  in  1; pixel clock, the only clock; all state updates on its rising edge.
REQ-007 reset  in  1; synchronous, active-high reset.
REQ-008 draw_x, draw_y  in  10 each; current raster coordinate.
REQ-009 vde  in  1; video display enable, high inside the active area.
REQ-010 vsync_pulse  in  1; one-cycle pulse at frame start.
REQ-011 spr_x, spr_y  in  10 each; sprite top-left corner.
REQ-012 spr_en  in  1; sprite visible when high.
REQ-013 flip_h  in  1; mirror the sprite horizontally when high.
REQ-014 anim_en  in  1; animation advance is enabled when high.
REQ-015 rom_addr  out  log2(FRAMES*SPR_W*SPR_H); combinational sprite ROM address.
REQ-016 rom_data  in  4; palette index from a synchronous ROM, valid one cycle after rom_addr.
REQ-017 pix_index  out  4; palette index for the downstream palette lookup, registered.
REQ-018 pix_valid  out  1; high when the sprite pixel is opaque, registered.
REQ-019 frame_idx  out  log2(FRAMES); current animation frame, registered.

Function
REQ-020 hit SHALL equal spr_en & vde & (draw_x >= spr_x) & (draw_x < spr_x+SPR_W) & (draw_y >= spr_y) & (draw_y < spr_y+SPR_H).
REQ-021 Each sum in REQ-020 SHALL be computed 11 bits wide so that it does not wrap, so a sprite that extends past coordinate 1023 is clipped and never aliases to column 0.
REQ-022 col = draw_x-spr_x when flip_h=0; col = SPR_W-1-(draw_x-spr_x) when flip_h=1. row = draw_y-spr_y.
REQ-023 rom_addr SHALL be frame_idx*SPR_W*SPR_H + row*SPR_W + col when hit=1.
REQ-024 rom_addr SHALL be frame_idx*SPR_W*SPR_H when hit=0 (row and col forced to 0).
REQ-025 hit SHALL be delayed one cycle (hit_d) to align it with rom_data.
REQ-026 On each edge, pix_valid SHALL be set to hit_d & (rom_data != TRANSP_IDX).
REQ-027 On each edge, pix_index SHALL be set to rom_data when the new pix_valid=1, and to 0 otherwise.
REQ-028 Latency: inputs sampled in cycle N SHALL produce pix_index and pix_valid in cycle N+2; throughput is one pixel per clock with no stalls.
REQ-029 The divider counter SHALL count vsync_pulse events while anim_en=1, from 0 to FRAME_DIV-1, then wrap to 0.
REQ-030 When the divider counter wraps, frame_idx SHALL increment modulo FRAMES in the same cycle.
REQ-031 When anim_en=0, the divider counter and frame_idx SHALL both hold.
REQ-032 frame_idx SHALL change only in a cycle that follows a vsync_pulse, so there is never a mid-frame frame switch.
REQ-033 A vsync_pulse that coincides with a hit pixel SHALL have that pixel fetched with the old frame_idx.

Reset
REQ-034 While reset=1 at an edge: pix_index=0, pix_valid=0, hit_d=0, divider counter=0, frame_idx=0.
REQ-035 Reset asserted mid-line SHALL clear the pipeline, and no stale pix_valid SHALL appear after reset is released.
REQ-036 The first valid pixel after release SHALL appear 2 cycles after the first hit cycle.
REQ-037 rom_addr is combinational and is therefore not reset; it SHALL equal 0 during reset only if hit=0.

Verification
REQ-038 spr_x=100, spr_y=50, flip_h=0, frame 0; raster at (100,50) with ROM[0]=4'h5 -> rom_addr=0, and pix_index=5 with pix_valid=1 two cycles later.
REQ-039 Same setup with flip_h=1 at (100,50) -> rom_addr=31; at (131,50) -> rom_addr=0; at (132,50) -> pix_valid=0.
REQ-040 ROM word = TRANSP_IDX inside the sprite -> pix_valid=0 and pix_index=0.
REQ-041 spr_x=1010 and draw_x sweeping 0..1023 -> hit only for 1010..1023, none at 0..21.
REQ-042 anim_en=1 with 8 vsync pulses -> frame_idx goes 0->1 on the 8th pulse, and after 32 pulses it wraps back to 0. With anim_en=0, pulses leave frame_idx unchanged.
REQ-043 Reset asserted for 1 cycle during a hit run -> pix_valid=0 and frame_idx=0 the next cycle, and valid output resumes 2 cycles after the next hit.
